// File: rtl/ram_onchip.sv
// ram_onchip: block-RAM bus slave at address 0 with per-byte write enables,
// 1- or 2-cycle read latency and an optional zeroing pass after reset.
module ram_onchip #(
   parameter int unsigned ADDR_HI    = 26,
   parameter int unsigned DEPTH_LOG2 = 14,
   parameter int unsigned READ_LAT   = 1,
   parameter bit          CLEAR      = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stb,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [ADDR_HI:2]  addr,
   input  logic [31:0]       data_in,
   output logic [31:0]       data_out,
   output logic              ack,
   output logic              init_done
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

   if (DEPTH_LOG2 < 4 || DEPTH_LOG2 + 2 > ADDR_HI) begin : g_bad_depth
      $error("ram_onchip: DEPTH_LOG2 must lie in 4..ADDR_HI-2");
   end
   if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
      $error("ram_onchip: READ_LAT must be 1 or 2");
   end

   typedef enum logic [1:0] {StClr, StIdle, StRdWait, StRdAck} state_e;

   localparam state_e ResetState = CLEAR ? StClr : StIdle;

   state_e                state_q, state_d;
   logic [DEPTH_LOG2-1:0] clr_cnt_q;
   logic [31:0]           rd1_q, rd2_q;
   logic [31:0]           mem_q [DEPTH];

   logic                  hit, en, rd_en;
   logic [DEPTH_LOG2-1:0] ad;
   logic                  wr_en;
   logic [DEPTH_LOG2-1:0] wr_idx;
   logic [31:0]           wr_data;
   logic [3:0]            wr_be;

   // Anything above the window is simply ignored; the bus decoder times it out.
   assign hit       = stb & ~|addr[ADDR_HI:DEPTH_LOG2+2];
   assign ad        = addr[DEPTH_LOG2+1:2];
   assign init_done = (state_q != StClr);
   assign en        = hit & init_done;
   assign data_out  = (READ_LAT == 2) ? rd2_q : rd1_q;

   always_comb begin
      state_d = state_q;
      ack     = 1'b0;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = ad;
      wr_data = data_in;
      wr_be   = be;
      unique case (state_q)
         StClr: begin
            wr_en   = 1'b1;
            wr_idx  = clr_cnt_q;
            wr_data = 32'h0;
            wr_be   = 4'hf;
            if (&clr_cnt_q) state_d = StIdle;
         end
         StIdle: begin
            if (en && we) begin
               wr_en = 1'b1;
               ack   = 1'b1;
            end else if (en) begin
               rd_en   = 1'b1;
               state_d = (READ_LAT == 2) ? StRdWait : StRdAck;
            end
         end
         StRdWait: begin
            state_d = en ? StRdAck : StIdle;
         end
         StRdAck: begin
            ack     = en & ~we;
            state_d = StIdle;
         end
         default: state_d = ResetState;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ResetState;
         clr_cnt_q <= '0;
         rd1_q     <= 32'h0;
         rd2_q     <= 32'h0;
      end else begin
         state_q <= state_d;
         if (state_q == StClr) clr_cnt_q <= clr_cnt_q + DEPTH_LOG2'(1);
         if (rd_en) rd1_q <= mem_q[ad];
         if (state_q == StRdWait) rd2_q <= rd1_q;
      end
   end

   // Array itself has no reset; only the clear pass initialises it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ram_onchip.sv
// Bench for ram_onchip: two instances (READ_LAT 1 and 2, 16 words, clear on)
// driven by directed accesses; a negedge monitor pops expected responses.
module tb_ram_onchip;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stb_v  [2];
   logic        we_v   [2];
   logic [3:0]  be_v   [2];
   logic [24:0] addr_v [2];
   logic [31:0] din_v  [2];
   logic [31:0] dout_v [2];
   logic        ack_v  [2];
   logic        done_v [2];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      bit          w;
      logic [31:0] d;
   } rec_t;

   rec_t q0[$];
   rec_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_onchip #(.ADDR_HI(26), .DEPTH_LOG2(4), .READ_LAT(1), .CLEAR(1'b1)) u_lat1 (
      .clk(clk), .rst(rst), .stb(stb_v[0]), .we(we_v[0]), .be(be_v[0]), .addr(addr_v[0]),
      .data_in(din_v[0]), .data_out(dout_v[0]), .ack(ack_v[0]), .init_done(done_v[0])
   );

   ram_onchip #(.ADDR_HI(26), .DEPTH_LOG2(4), .READ_LAT(2), .CLEAR(1'b1)) u_lat2 (
      .clk(clk), .rst(rst), .stb(stb_v[1]), .we(we_v[1]), .be(be_v[1]), .addr(addr_v[1]),
      .data_in(din_v[1]), .data_out(dout_v[1]), .ack(ack_v[1]), .init_done(done_v[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every ack must match a queued access; reads also compare data.
   always @(negedge clk) begin : monitor
      rec_t r;
      int   sz;
      for (int d = 0; d < 2; d++) begin
         if (ack_v[d] === 1'b1) begin
            sz = (d == 0) ? q0.size() : q1.size();
            if (sz == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack dut%0d at cycle %0d: got ack=1, expected 0", d, cyc);
            end else begin
               if (d == 0) r = q0.pop_front();
               else r = q1.pop_front();
               check($sformatf("ack_kind_dut%0d", d), {31'h0, we_v[d]}, {31'h0, r.w});
               if (!r.w) check($sformatf("rd_data_dut%0d", d), dout_v[d], r.d);
            end
         end
      end
   end

   // Start at #1 after a rising edge; returns at #1 after the edge closing the access.
   task automatic access(input int d, input bit w, input logic [3:0] b, input logic [24:0] a,
                         input logic [31:0] din, input logic [31:0] exp_d, input int exp_lat,
                         output int ack_cyc);
      rec_t r;
      int   n;
      n   = 0;
      r.w = w;
      r.d = exp_d;
      if (d == 0) q0.push_back(r);
      else q1.push_back(r);
      stb_v[d]  = 1'b1;
      we_v[d]   = w;
      be_v[d]   = b;
      addr_v[d] = a;
      din_v[d]  = din;
      @(negedge clk);
      while (ack_v[d] !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      ack_cyc = cyc;
      check($sformatf("latency_dut%0d_%s_%0h", d, w ? "wr" : "rd", a), n, exp_lat);
      @(posedge clk);
      #1;
      stb_v[d] = 1'b0;
   endtask

   task automatic count_clear(input int d);
      int n;
      n = 0;
      @(negedge clk);
      while (done_v[d] !== 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check($sformatf("clear_cycles_dut%0d", d), n, DEPTH);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int c0, c1, tmp, nack;
      for (int d = 0; d < 2; d++) begin
         stb_v[d]  = 1'b0;
         we_v[d]   = 1'b0;
         be_v[d]   = 4'h0;
         addr_v[d] = '0;
         din_v[d]  = '0;
      end
      #1 rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset_ack_dut%0d", d), {31'h0, ack_v[d]}, 32'h0);
         check($sformatf("reset_dout_dut%0d", d), dout_v[d], 32'h0);
         check($sformatf("reset_done_dut%0d", d), {31'h0, done_v[d]}, 32'h0);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Read held through the clear on lat1; lat2 times the clear.
      fork
         access(0, 1'b0, 4'h0, 25'd5, 32'h0, 32'h0, DEPTH + 1, tmp);
         count_clear(1);
      join

      // Every word reads zero; back-to-back read spacing is READ_LAT+1.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < DEPTH; i++) begin
            access(d, 1'b0, 4'h0, 25'(i), 32'h0, 32'h0, d + 1, c1);
            if (i > 0) check($sformatf("rd_spacing_dut%0d", d), c1 - c0, d + 2);
            c0 = c1;
         end
      end

      // Byte-enable merge, boundary word, be=0 write, read-after-write.
      for (int d = 0; d < 2; d++) begin
         access(d, 1'b1, 4'hf, 25'd3, 32'hDEAD_BEEF, 32'h0, 0, c0);
         access(d, 1'b1, 4'b0101, 25'd3, 32'h1122_3344, 32'h0, 0, c1);
         check($sformatf("wr_spacing_dut%0d", d), c1 - c0, 1);
         access(d, 1'b0, 4'h0, 25'd3, 32'h0, 32'hDE22_BE44, d + 1, tmp);
         access(d, 1'b1, 4'hf, 25'd0, 32'hA5A5_0001, 32'h0, 0, tmp);
         access(d, 1'b1, 4'hf, 25'd15, 32'h0F0F_F0F0, 32'h0, 0, tmp);
         access(d, 1'b1, 4'h0, 25'd15, 32'hFFFF_FFFF, 32'h0, 0, tmp);
         access(d, 1'b0, 4'h0, 25'd15, 32'h0, 32'h0F0F_F0F0, d + 1, tmp);
         access(d, 1'b0, 4'h0, 25'd0, 32'h0, 32'hA5A5_0001, d + 1, tmp);
      end

      // Out-of-window write (byte address 0x0001_000C) is never acked.
      nack       = 0;
      stb_v[1]   = 1'b1;
      we_v[1]    = 1'b1;
      be_v[1]    = 4'hf;
      addr_v[1]  = 25'h4003;
      din_v[1]   = 32'hFFFF_FFFF;
      repeat (20) begin
         @(negedge clk);
         if (ack_v[1] === 1'b1) nack++;
      end
      check("oow_acks", nack, 0);
      @(posedge clk);
      #1 stb_v[1] = 1'b0;
      access(1, 1'b0, 4'h0, 25'd3, 32'h0, 32'hDE22_BE44, 2, tmp);

      // Read abandoned in RD_WAIT, then an immediate write.
      stb_v[1]  = 1'b1;
      we_v[1]   = 1'b0;
      addr_v[1] = 25'd0;
      @(posedge clk);
      #1 stb_v[1] = 1'b0;
      @(posedge clk);
      #1;
      access(1, 1'b1, 4'hf, 25'd7, 32'h0000_0077, 32'h0, 0, tmp);
      access(1, 1'b0, 4'h0, 25'd7, 32'h0, 32'h0000_0077, 2, tmp);
      access(0, 1'b0, 4'h0, 25'd3, 32'h0, 32'hDE22_BE44, 1, tmp);

      // Reset mid-read (lat2 sits in RD_WAIT) clears outputs asynchronously.
      stb_v[1]  = 1'b1;
      we_v[1]   = 1'b0;
      addr_v[1] = 25'd3;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      stb_v[1] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("midrd_ack_dut%0d", d), {31'h0, ack_v[d]}, 32'h0);
         check($sformatf("midrd_dout_dut%0d", d), dout_v[d], 32'h0);
         check($sformatf("midrd_done_dut%0d", d), {31'h0, done_v[d]}, 32'h0);
      end
      @(posedge clk);
      #1 rst = 1'b1;

      // Reset mid-clear: the pass restarts from word 0.
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      #1 check("midclr_done_dut0", {31'h0, done_v[0]}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      fork
         count_clear(0);
         count_clear(1);
      join
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         access(d, 1'b0, 4'h0, 25'd15, 32'h0, 32'h0, d + 1, tmp);
         access(d, 1'b0, 4'h0, 25'd3, 32'h0, 32'h0, d + 1, tmp);
      end
      access(1, 1'b0, 4'h0, 25'd7, 32'h0, 32'h0, 2, tmp);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
